// File: rtl/regfile_sweep.sv
// Single-clock register file with one write port, one pipelined read port and a clear sweeper.
// Optional per-word even parity enabled by defining REGFILE_PARITY_EN.
module regfile_sweep #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter int                RD_LAT  = 2,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
`ifdef REGFILE_PARITY_EN
    ,
    input  logic              wr_par_inj,
    output logic              par_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
`ifdef REGFILE_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic              idle;
    logic              rd_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [MEM_W-1:0]  mem_wword;
    logic [MEM_W-1:0]  clear_word;
    logic [MEM_W-1:0]  wr_word;

    logic [MEM_W-1:0]  mem [DEPTH];

    assign idle      = (state_reg == ST_IDLE);
    assign busy      = !idle;
    assign rd_accept = rd_en && idle;

`ifdef REGFILE_PARITY_EN
    assign clear_word = {^CLR_VAL, CLR_VAL};
    assign wr_word    = {(^wr_data) ^ wr_par_inj, wr_data};
`else
    assign clear_word = CLR_VAL;
    assign wr_word    = wr_data;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == {ADDR_W{1'b1}}) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The sweeper owns the write port while clearing; user writes are dropped.
    always_comb begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wword = clear_word;
        if (idle) begin
            mem_we    = wr_en;
            mem_waddr = wr_addr;
            mem_wword = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    // Read pipeline: stage 0 is the registered array read, later stages only delay.
    // Each stage loads data only with a valid token, so the output holds between reads.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic             in_valid;
            logic [MEM_W-1:0] in_word;
            logic             valid_reg;
            logic [MEM_W-1:0] word_reg;

            if (gi == 0) begin : g_head
                assign in_valid = rd_accept;
                assign in_word  = mem[rd_addr];
            end else begin : g_tail
                assign in_valid = g_stage[gi-1].valid_reg;
                assign in_word  = g_stage[gi-1].word_reg;
            end

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    valid_reg <= 1'b0;
                    word_reg  <= '0;
                end else begin
                    valid_reg <= in_valid;
                    if (in_valid) begin
                        word_reg <= in_word;
                    end
                end
            end
        end
    endgenerate

    assign rd_valid = g_stage[RD_LAT-1].valid_reg;
    assign rd_data  = g_stage[RD_LAT-1].word_reg[DATA_W-1:0];

`ifdef REGFILE_PARITY_EN
    assign par_err = rd_valid &&
                     ((^g_stage[RD_LAT-1].word_reg[DATA_W-1:0]) != g_stage[RD_LAT-1].word_reg[DATA_W]);
`endif

endmodule

// File: tb/tb_regfile_sweep.sv
// Scoreboard bench for regfile_sweep: reference array model, expected read data queued at issue.
// Parity checks are compiled in when REGFILE_PARITY_EN is defined.
module tb_regfile_sweep;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              nreset;
    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
`ifdef REGFILE_PARITY_EN
    logic              wr_par_inj;
    logic              par_err;
    bit                model_bad [DEPTH];
    bit                par_q [$];
`endif

    int                n_cmp = 0;
    int                n_bad = 0;
    int                n_rd  = 0;
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    bit                model_idle;

    always #5 clk = ~clk;

    regfile_sweep #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .CLR_VAL(8'h00)
    ) dut (
        .clk     (clk),
        .nreset  (nreset),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid)
`ifdef REGFILE_PARITY_EN
        ,
        .wr_par_inj(wr_par_inj),
        .par_err   (par_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
`ifdef REGFILE_PARITY_EN
            model_bad[i] = 1'b0;
`endif
        end
    endtask

    // Drives one cycle of stimulus; the model applies read-before-write, then a clear.
    task automatic issue(input bit clr, input bit we, input int wa, input int wd,
                         input bit re, input int ra, input bit inj = 1'b0);
        clr_req = clr;
        wr_en   = we;
        wr_addr = ADDR_W'(wa);
        wr_data = DATA_W'(wd);
        rd_en   = re;
        rd_addr = ADDR_W'(ra);
`ifdef REGFILE_PARITY_EN
        wr_par_inj = inj;
`endif
        if (model_idle) begin
            if (re) begin
                exp_q.push_back(model[ra]);
`ifdef REGFILE_PARITY_EN
                par_q.push_back(model_bad[ra]);
`endif
            end
            if (we) begin
                model[wa] = DATA_W'(wd);
`ifdef REGFILE_PARITY_EN
                model_bad[wa] = inj;
`endif
            end
            if (clr) begin
                model_idle = 1'b0;
                model_clear();
            end
        end
        cyc();
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
`ifdef REGFILE_PARITY_EN
        wr_par_inj = 1'b0;
`endif
        if (inj) begin
            inj = 1'b0;
        end
    endtask

    task automatic count_busy(input string tag, input int exp_len);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc();
        end
        check(tag, n, exp_len);
        model_idle = 1'b1;
    endtask

    task automatic drain(input string tag);
        repeat (RD_LAT + 2) cyc();
        check(tag, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                n_rd++;
                $display("read #%0d: data=0x%02h expected=0x%02h", n_rd, rd_data, e);
                check("rd_data", rd_data, e);
`ifdef REGFILE_PARITY_EN
                check("par_err", par_err, par_q.pop_front());
`endif
            end
        end
    end

    initial begin
        int base;
        nreset  = 1'b0;
        clr_req = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
`ifdef REGFILE_PARITY_EN
        wr_par_inj = 1'b0;
`endif
        model_idle = 1'b0;
        model_clear();

        // Reset state and initial sweep
        repeat (3) cyc();
        check("reset_busy", busy, 1);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        nreset = 1'b1;
        count_busy("busy_after_reset", 16);
        for (int a = 0; a < DEPTH; a++) issue(0, 0, 0, 0, 1, a);
        drain("drain_initial");

        // Read latency and single-cycle valid
        issue(0, 1, 3, 8'hA5, 0, 0);
        issue(0, 0, 0, 0, 1, 3);
        check("latency_early_valid", rd_valid, 0);
        cyc();
        check("latency_valid", rd_valid, 1);
        check("latency_data", rd_data, 8'hA5);
        cyc();
        check("latency_single_pulse", rd_valid, 0);
        drain("drain_latency");

        // Fill and back-to-back reads
        for (int a = 0; a < DEPTH; a++) issue(0, 1, a, a * 8'h11, 0, 0);
        base = n_rd;
        for (int a = 0; a < DEPTH; a++) issue(0, 0, 0, 0, 1, a);
        drain("drain_burst");
        check("burst_count", n_rd - base, 16);

        // Same-cycle write and read of one address returns old data
        issue(0, 1, 5, 8'h55, 0, 0);
        issue(0, 1, 5, 8'h3C, 1, 5);
        issue(0, 0, 0, 0, 1, 5);
        drain("drain_rbw");

        // Clear request with an in-flight read; accesses during sweep dropped
        issue(1, 0, 0, 0, 1, 7);
        issue(0, 1, 2, 8'h77, 0, 0);
        issue(0, 0, 0, 0, 1, 2);
        count_busy("busy_after_clr", 14);
        for (int a = 0; a < DEPTH; a++) issue(0, 0, 0, 0, 1, a);
        drain("drain_after_clr");

        // Reset discards a read in flight
        issue(0, 1, 9, 8'h99, 0, 0);
        issue(0, 0, 0, 0, 1, 9);
        drain("drain_pre_reset");
        issue(0, 0, 0, 0, 1, 9);
        nreset = 1'b0;
        exp_q.delete();
`ifdef REGFILE_PARITY_EN
        par_q.delete();
`endif
        model_idle = 1'b0;
        model_clear();
        #1;
        check("midread_reset_rd_data", rd_data, 0);
        check("midread_reset_rd_valid", rd_valid, 0);
        cyc();
        nreset = 1'b1;
        count_busy("busy_after_midread_reset", 16);

        // Reset pulse in the middle of a sweep restarts it
        issue(0, 1, 4, 8'h44, 0, 0);
        issue(1, 0, 0, 0, 0, 0);
        repeat (7) cyc();
        nreset = 1'b0;
        #1;
        check("midsweep_reset_busy", busy, 1);
        cyc();
        nreset = 1'b1;
        model_idle = 1'b0;
        count_busy("busy_after_midsweep_reset", 16);
        for (int a = 0; a < DEPTH; a++) issue(0, 0, 0, 0, 1, a);
        drain("drain_after_midsweep_reset");

`ifdef REGFILE_PARITY_EN
        // Injected parity error versus clean word
        issue(0, 1, 7, 8'h01, 0, 0, 1'b1);
        issue(0, 1, 8, 8'h03, 0, 0);
        issue(0, 0, 0, 0, 1, 7);
        issue(0, 0, 0, 0, 1, 8);
        drain("drain_parity");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
